// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Optional checksum feature: INSTR_LOADER_CHECKSUM_EN.
package instr_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_WIDTH      = 16;
    localparam int WORD_WIDTH     = 32;
    localparam int IDX_WIDTH      = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_e;

    function automatic logic state_accepts(input state_e s);
        return (s == ST_LEN0) || (s == ST_LEN1) ||
               (s == ST_DATA) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Packs accepted bytes little-endian into 32-bit words; strobes word_valid_o
// combinationally on the 4th byte so the caller can register the full word.
module word_assembler
    import instr_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            byte_i,
    input  logic                  xfer_i,
    input  logic                  clear_i,
    output logic [WORD_WIDTH-1:0] word_o,
    output logic                  word_valid_o
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(BYTES_PER_WORD - 1);

    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [WORD_WIDTH-9:0] lanes_q, lanes_d;

    always_comb begin
        idx_d        = idx_q;
        lanes_d      = lanes_q;
        word_valid_o = 1'b0;
        word_o       = {byte_i, lanes_q};
        if (clear_i) begin
            idx_d   = '0;
            lanes_d = '0;
        end else if (xfer_i) begin
            idx_d = idx_q + IDX_WIDTH'(1);
            case (idx_q)
                IDX_WIDTH'(0): lanes_d[7:0]   = byte_i;
                IDX_WIDTH'(1): lanes_d[15:8]  = byte_i;
                IDX_WIDTH'(2): lanes_d[23:16] = byte_i;
                default:       lanes_d        = lanes_q;
            endcase
            if (idx_q == LAST_IDX) begin
                word_valid_o = 1'b1;
                lanes_d      = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            lanes_q <= '0;
        end else begin
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Boot loader: LEN0/LEN1/payload[/CHK] byte frame -> sequential imem writes.
// Optional trailing XOR checksum byte: INSTR_LOADER_CHECKSUM_EN.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             byte_i,
    input  logic                   byte_valid_i,
    output logic                   byte_ready_o,
    input  logic                   start_i,
    output logic                   imem_we_o,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    output logic [INSTR_WIDTH-1:0] imem_data_o,
    output logic                   cpu_rst_o,
    output logic                   done_o,
    output logic                   err_o
);

    localparam logic [LEN_WIDTH:0] MAX_WORDS = (LEN_WIDTH + 1)'(1) << ADDR_WIDTH;

`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam state_e END_STATE = ST_CHK;
    localparam logic   END_DONE  = 1'b0;
`else
    localparam state_e END_STATE = ST_DONE;
    localparam logic   END_DONE  = 1'b1;
`endif

    state_e                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   we_q, we_d;
    logic [INSTR_WIDTH-1:0] data_q, data_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   cpu_rst_q, cpu_rst_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]             xor_q, xor_d;
`endif

    logic                   xfer;
    logic                   asm_clear;
    logic [WORD_WIDTH-1:0]  asm_word;
    logic                   asm_valid;
    logic [LEN_WIDTH-1:0]   n_words;
    logic [LEN_WIDTH-1:0]   cnt_inc;

    assign byte_ready_o = state_accepts(state_q);
    assign xfer         = byte_valid_i && byte_ready_o;
    assign n_words      = {byte_i, len_q[7:0]};
    assign cnt_inc      = cnt_q + LEN_WIDTH'(1);

    word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .byte_i       (byte_i),
        .xfer_i       (xfer && (state_q == ST_DATA)),
        .clear_i      (asm_clear),
        .word_o       (asm_word),
        .word_valid_o (asm_valid)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        we_d      = 1'b0;
        data_d    = data_q;
        done_d    = done_q;
        err_d     = err_q;
        cpu_rst_d = cpu_rst_q;
        asm_clear = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
        xor_d     = xor_q;
`endif
        // Address advances the cycle after each write strobe.
        if (we_q) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
        end
        case (state_q)
            ST_LEN0: begin
                if (xfer) begin
                    len_d[7:0] = byte_i;
                    state_d    = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (xfer) begin
                    len_d = n_words;
                    if ({1'b0, n_words} > MAX_WORDS) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else if (n_words == '0) begin
                        state_d = END_STATE;
                        if (END_DONE) begin
                            done_d    = 1'b1;
                            cpu_rst_d = 1'b0;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                if (xfer) begin
                    xor_d = xor_q ^ byte_i;
                end
`endif
                if (asm_valid) begin
                    we_d   = 1'b1;
                    data_d = INSTR_WIDTH'(asm_word);
                    cnt_d  = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = END_STATE;
                        if (END_DONE) begin
                            done_d    = 1'b1;
                            cpu_rst_d = 1'b0;
                        end
                    end
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (xfer) begin
                    if (byte_i == xor_q) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            ST_DONE, ST_ERR: begin
                if (start_i) begin
                    state_d   = ST_LEN0;
                    cpu_rst_d = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    addr_d    = '0;
                    len_d     = '0;
                    cnt_d     = '0;
                    asm_clear = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    xor_d     = '0;
`endif
                end
            end
            default: begin
                state_d = ST_LEN0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_LEN0;
            len_q     <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            xor_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cpu_rst_q <= cpu_rst_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
        end
    end

    assign imem_we_o   = we_q;
    assign imem_addr_o = addr_q;
    assign imem_data_o = data_q;
    assign cpu_rst_o   = cpu_rst_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader; checksum scenarios are
// exercised when INSTR_LOADER_CHECKSUM_EN is defined.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  byte_i = 8'h00;
    logic        byte_valid_i = 1'b0;
    logic        byte_ready_o;
    logic        start_i = 1'b0;
    logic        imem_we_o;
    logic [7:0]  imem_addr_o;
    logic [31:0] imem_data_o;
    logic        cpu_rst_o;
    logic        done_o;
    logic        err_o;

    int errors = 0;
    int checks = 0;

    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];

    instr_loader #(.INSTR_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .start_i      (start_i),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_data_o  (imem_data_o),
        .cpu_rst_o    (cpu_rst_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we_o) begin
            wa_q.push_back(imem_addr_o);
            wd_q.push_back(imem_data_o);
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        checks++;
        if (byte_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL send_ready byte=%h got=%b exp=1", b, byte_ready_o);
        end
        byte_i       = b;
        byte_valid_i = 1'b1;
        cyc();
        byte_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        byte_valid_i = 1'b0;
        start_i = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if (byte_ready_o !== 1'b1 || imem_we_o !== 1'b0 || imem_addr_o !== 8'h00 ||
            imem_data_o !== 32'h0 || cpu_rst_o !== 1'b1 || done_o !== 1'b0 ||
            err_o !== 1'b0) begin
            errors++;
            $display("FAIL %s got rdy=%b we=%b a=%h d=%h crst=%b dn=%b er=%b exp 1 0 00 0 1 0 0",
                     tag, byte_ready_o, imem_we_o, imem_addr_o, imem_data_o,
                     cpu_rst_o, done_o, err_o);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_vals("reset_state");
    endtask

    task automatic test_two_words();
        do_reset();
        send(8'h02); send(8'h00);
        send(8'h13); send(8'h05); send(8'h10); send(8'h00);
        send(8'h63); send(8'h14); send(8'hB5); send(8'h00);
        checks++;
        if (imem_we_o !== 1'b1 || imem_addr_o !== 8'h01 || imem_data_o !== 32'h00B51463) begin
            errors++;
            $display("FAIL two_last_write got we=%b a=%h d=%h exp 1 01 00b51463",
                     imem_we_o, imem_addr_o, imem_data_o);
        end
`ifndef INSTR_LOADER_CHECKSUM_EN
        checks++;
        if (done_o !== 1'b1 || cpu_rst_o !== 1'b0) begin
            errors++;
            $display("FAIL two_done_edge got done=%b crst=%b exp 1 0", done_o, cpu_rst_o);
        end
        cyc();
`else
        checks++;
        if (done_o !== 1'b0 || cpu_rst_o !== 1'b1) begin
            errors++;
            $display("FAIL two_pre_chk got done=%b crst=%b exp 0 1", done_o, cpu_rst_o);
        end
        send(8'hC4);
        checks++;
        if (done_o !== 1'b1 || cpu_rst_o !== 1'b0) begin
            errors++;
            $display("FAIL two_chk_done got done=%b crst=%b exp 1 0", done_o, cpu_rst_o);
        end
`endif
        checks++;
        if (imem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL two_strobe_len got we=%b exp 0", imem_we_o);
        end
        cyc();
        checks++;
        if (wa_q.size() != 2) begin
            errors++;
            $display("FAIL two_count got=%0d exp=2", wa_q.size());
        end else if (wa_q[0] !== 8'h00 || wd_q[0] !== 32'h00100513 ||
                     wa_q[1] !== 8'h01 || wd_q[1] !== 32'h00B51463) begin
            errors++;
            $display("FAIL two_writes got %h:%h %h:%h exp 00:00100513 01:00b51463",
                     wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
        end
    endtask

    task automatic test_restart();
        wa_q.delete();
        wd_q.delete();
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        checks++;
        if (cpu_rst_o !== 1'b1 || done_o !== 1'b0 || byte_ready_o !== 1'b1 ||
            imem_addr_o !== 8'h00) begin
            errors++;
            $display("FAIL restart_state got crst=%b done=%b rdy=%b a=%h exp 1 0 1 00",
                     cpu_rst_o, done_o, byte_ready_o, imem_addr_o);
        end
        send(8'h01); send(8'h00);
        send(8'h93); send(8'h00); send(8'h00); send(8'h00);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send(8'h93);
`endif
        cyc();
        checks++;
        if (wa_q.size() != 1 || wa_q[0] !== 8'h00 || wd_q[0] !== 32'h00000093) begin
            errors++;
            $display("FAIL restart_write got n=%0d exp 1 write of 00000093 at 00", wa_q.size());
        end
        checks++;
        if (done_o !== 1'b1 || cpu_rst_o !== 1'b0) begin
            errors++;
            $display("FAIL restart_done got done=%b crst=%b exp 1 0", done_o, cpu_rst_o);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        send(8'h01); send(8'h01);
        checks++;
        if (err_o !== 1'b1 || byte_ready_o !== 1'b0 || cpu_rst_o !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL overflow_err got err=%b rdy=%b crst=%b done=%b exp 1 0 1 0",
                     err_o, byte_ready_o, cpu_rst_o, done_o);
        end
        byte_i = 8'h55;
        byte_valid_i = 1'b1;
        cyc(); cyc();
        byte_valid_i = 1'b0;
        checks++;
        if (wa_q.size() != 0 || err_o !== 1'b1 || cpu_rst_o !== 1'b1) begin
            errors++;
            $display("FAIL overflow_nowrite got n=%0d err=%b crst=%b exp 0 1 1",
                     wa_q.size(), err_o, cpu_rst_o);
        end
    endtask

    task automatic test_valid_toggle();
        logic [7:0] pay[4];
        pay = '{8'h13, 8'h05, 8'h10, 8'h00};
        do_reset();
        send(8'h01); send(8'h00);
        for (int i = 0; i < 3; i++) begin
            send(pay[i]);
            cyc();
            checks++;
            if (imem_we_o !== 1'b0) begin
                errors++;
                $display("FAIL toggle_early_we byte=%0d got=%b exp=0", i, imem_we_o);
            end
        end
        send(pay[3]);
        checks++;
        if (imem_we_o !== 1'b1 || imem_addr_o !== 8'h00 || imem_data_o !== 32'h00100513) begin
            errors++;
            $display("FAIL toggle_write got we=%b a=%h d=%h exp 1 00 00100513",
                     imem_we_o, imem_addr_o, imem_data_o);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        send(8'h02); send(8'h00);
        send(8'h13); send(8'h05); send(8'h10); send(8'h00);
        send(8'h63); send(8'h14);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_reset_vals("rst_mid_state");
        wa_q.delete();
        wd_q.delete();
        send(8'h01); send(8'h00);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        checks++;
        if (imem_we_o !== 1'b1 || imem_addr_o !== 8'h00 || imem_data_o !== 32'hDDCCBBAA) begin
            errors++;
            $display("FAIL rst_mid_write got we=%b a=%h d=%h exp 1 00 ddccbbaa",
                     imem_we_o, imem_addr_o, imem_data_o);
        end
    endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        send(8'h01); send(8'h00);
        send(8'h13); send(8'h05); send(8'h10); send(8'h00);
        send(8'h06);
        checks++;
        if (done_o !== 1'b1 || err_o !== 1'b0 || cpu_rst_o !== 1'b0) begin
            errors++;
            $display("FAIL chk_good got done=%b err=%b crst=%b exp 1 0 0", done_o, err_o, cpu_rst_o);
        end
        do_reset();
        send(8'h01); send(8'h00);
        send(8'h13); send(8'h05); send(8'h10); send(8'h00);
        send(8'h07);
        cyc();
        checks++;
        if (err_o !== 1'b1 || done_o !== 1'b0 || cpu_rst_o !== 1'b1) begin
            errors++;
            $display("FAIL chk_bad got done=%b err=%b crst=%b exp 0 1 1", done_o, err_o, cpu_rst_o);
        end
        checks++;
        if (wa_q.size() != 1 || wa_q[0] !== 8'h00 || wd_q[0] !== 32'h00100513) begin
            errors++;
            $display("FAIL chk_bad_write got n=%0d exp 1 write of 00100513 at 00", wa_q.size());
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_two_words();
        test_restart();
        test_overflow();
        test_valid_toggle();
        test_rst_mid();
`ifdef INSTR_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
